// File: rtl/mem_responder.sv
// Memory-side responder: 2**ADDR_W x DATA_W storage with registered read data,
// a clear sweep after reset, sticky read/write conflict flag and saturating activity counters.
module mem_responder #(
   parameter int                ADDR_W   = 5,
   parameter int                DATA_W   = 8,
   parameter int                CNT_W    = 16,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              ready,
   output logic              err,
   input  logic              err_clr,
   output logic [CNT_W-1:0]  wr_count,
   output logic [CNT_W-1:0]  rd_count
);

   localparam int DEPTH = 2 ** ADDR_W;
   // One extra sweep bit: the cycle after the last word marks sweep completion.
   localparam logic [ADDR_W:0] SWEEP_END = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {INIT, RUN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W:0]     sweep_q, sweep_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic                rd_valid_q, rd_valid_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    wr_count_q, wr_count_d;
   logic [CNT_W-1:0]    rd_count_q, rd_count_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;

   always_comb begin
      state_d    = state_q;
      sweep_d    = sweep_q;
      data_out_d = data_out_q;
      rd_valid_d = 1'b0;
      ready_d    = ready_q;
      err_d      = err_q;
      wr_count_d = wr_count_q;
      rd_count_d = rd_count_q;
      mem_we     = 1'b0;
      mem_waddr  = addr;
      mem_wdata  = data_in;

      if (err_clr) err_d = 1'b0;

      case (state_q)
         INIT: begin
            if (sweep_q == SWEEP_END) begin
               state_d = RUN;
               ready_d = 1'b1;
            end else begin
               mem_we    = 1'b1;
               mem_waddr = sweep_q[ADDR_W-1:0];
               mem_wdata = INIT_VAL;
               sweep_d   = sweep_q + 1'b1;
            end
         end
         RUN: begin
            if (read && write) begin
               // A conflict wins over a simultaneous clear.
               err_d = 1'b1;
            end else if (write) begin
               mem_we = 1'b1;
               if (wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
            end else if (read) begin
               data_out_d = mem_q[addr];
               rd_valid_d = 1'b1;
               if (rd_count_q != '1) rd_count_d = rd_count_q + 1'b1;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= INIT;
         sweep_q    <= '0;
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
         wr_count_q <= '0;
         rd_count_q <= '0;
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         data_out_q <= data_out_d;
         rd_valid_q <= rd_valid_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
         wr_count_q <= wr_count_d;
         rd_count_q <= rd_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   assign data_out = data_out_q;
   assign rd_valid = rd_valid_q;
   assign ready    = ready_q;
   assign err      = err_q;
   assign wr_count = wr_count_q;
   assign rd_count = rd_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; a second instance with 2-bit counters shares all inputs.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [4:0]  addr = '0;
   logic [7:0]  data_in = '0;
   logic        err_clr = 1'b0;
   logic [7:0]  data_out, data_out2;
   logic        rd_valid, rd_valid2, ready, ready2, err, err2;
   logic [15:0] wr_count, rd_count;
   logic [1:0]  wr_count2, rd_count2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_responder dut (
      .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
      .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid), .ready(ready),
      .err(err), .err_clr(err_clr), .wr_count(wr_count), .rd_count(rd_count)
   );

   mem_responder #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
      .data_in(data_in), .data_out(data_out2), .rd_valid(rd_valid2), .ready(ready2),
      .err(err2), .err_clr(err_clr), .wr_count(wr_count2), .rd_count(rd_count2)
   );

   // Stimulus helpers: called at a negedge, return at the negedge after the sampling edge.
   task automatic do_reset();
      rst_n = 1'b0; read = 1'b0; write = 1'b0; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic reset_ready();
      do_reset();
      repeat (33) @(negedge clk);
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      write = 1'b1; addr = a; data_in = d;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a);
      read = 1'b1; addr = a;
      @(negedge clk);
      read = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] ra [3];
      ra[0] = 5'h00; ra[1] = 5'h0F; ra[2] = 5'h1F;
      rst_n = 1'b0; read = 1'b0; write = 1'b0; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({data_out, rd_valid, ready, err, wr_count, rd_count} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_state: got dout=%h rv=%b rdy=%b err=%b wc=%0d rc=%0d, want all 0",
                  data_out, rd_valid, ready, err, wr_count, rd_count);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         n_tests++;
         if (ready !== (k >= 32)) begin
            n_fail++;
            $display("FAIL ready_edge%0d: got %b want %b", k, ready, (k >= 32));
         end
      end
      for (int i = 0; i < 3; i++) begin
         rd(ra[i]);
         n_tests++;
         if (data_out !== 8'h00 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_read_%h: got %h rv=%b want 00 rv=1", ra[i], data_out, rd_valid);
         end
      end
      @(negedge clk);
      n_tests++;
      if (rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_valid_idle: got %b want 0", rd_valid);
      end
   endtask

   task automatic test_write_read();
      reset_ready();
      wr(5'h03, 8'hA5);
      wr(5'h1F, 8'h3C);
      rd(5'h03);
      n_tests++;
      if (data_out !== 8'hA5 || rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL read_03: got %h rv=%b want a5 rv=1", data_out, rd_valid);
      end
      rd(5'h1F);
      n_tests++;
      if (data_out !== 8'h3C || rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL read_1f: got %h rv=%b want 3c rv=1", data_out, rd_valid);
      end
      n_tests++;
      if (wr_count !== 16'd2 || rd_count !== 16'd2) begin
         n_fail++;
         $display("FAIL counts_wr_rd: got wc=%0d rc=%0d want 2 2", wr_count, rd_count);
      end
   endtask

   task automatic test_back_to_back();
      wr(5'h0A, 8'h77);
      rd(5'h0A);
      n_tests++;
      if (data_out !== 8'h77) begin
         n_fail++;
         $display("FAIL wr_then_rd: got %h want 77", data_out);
      end
      // Held read strobe gives one access per cycle.
      read = 1'b1; addr = 5'h03;
      @(negedge clk);
      addr = 5'h1F;
      @(negedge clk);
      read = 1'b0;
      n_tests++;
      if (data_out !== 8'h3C || rd_valid !== 1'b1 || rd_count !== 16'd5) begin
         n_fail++;
         $display("FAIL held_read: got %h rv=%b rc=%0d want 3c 1 5", data_out, rd_valid, rd_count);
      end
   endtask

   task automatic test_conflict();
      reset_ready();
      wr(5'h05, 8'h11);
      read = 1'b1; write = 1'b1; addr = 5'h05; data_in = 8'hEE;
      @(negedge clk);
      read = 1'b0; write = 1'b0;
      n_tests++;
      if (err !== 1'b1 || rd_valid !== 1'b0 || data_out !== 8'h00 ||
          wr_count !== 16'd1 || rd_count !== 16'd0) begin
         n_fail++;
         $display("FAIL conflict: got err=%b rv=%b dout=%h wc=%0d rc=%0d want 1 0 00 1 0",
                  err, rd_valid, data_out, wr_count, rd_count);
      end
      rd(5'h05);
      n_tests++;
      if (data_out !== 8'h11) begin
         n_fail++;
         $display("FAIL conflict_no_write: got %h want 11", data_out);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clr: got %b want 0", err);
      end
      read = 1'b1; write = 1'b1; err_clr = 1'b1;
      @(negedge clk);
      read = 1'b0; write = 1'b0; err_clr = 1'b0;
      n_tests++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL conflict_vs_clr: got %b want 1", err);
      end
      @(negedge clk);
      n_tests++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: got %b want 1", err);
      end
   endtask

   task automatic test_reset_mid_sweep();
      reset_ready();
      wr(5'h02, 8'h55);
      rd(5'h02);
      n_tests++;
      if (data_out !== 8'h55) begin
         n_fail++;
         $display("FAIL pre_reset_read: got %h want 55", data_out);
      end
      do_reset();
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 33; k++) begin
         @(negedge clk);
         n_tests++;
         if (ready !== (k >= 32)) begin
            n_fail++;
            $display("FAIL resweep_ready_edge%0d: got %b want %b", k, ready, (k >= 32));
         end
      end
      rd(5'h02);
      n_tests++;
      if (data_out !== 8'h00 || wr_count !== 16'd0) begin
         n_fail++;
         $display("FAIL resweep_clear: got %h wc=%0d want 00 0", data_out, wr_count);
      end
   endtask

   task automatic test_saturate();
      logic [1:0] exp2 [5];
      exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3; exp2[4] = 2'd3;
      reset_ready();
      for (int i = 0; i < 5; i++) begin
         wr(5'(i), 8'(i + 1));
         n_tests++;
         if (wr_count2 !== exp2[i]) begin
            n_fail++;
            $display("FAIL sat_wr%0d: got %0d want %0d", i, wr_count2, exp2[i]);
         end
      end
      n_tests++;
      if (wr_count !== 16'd5) begin
         n_fail++;
         $display("FAIL wide_wr_count: got %0d want 5", wr_count);
      end
      // INIT ignores strobes entirely.
      do_reset();
      wr(5'h04, 8'h99);
      read = 1'b1; write = 1'b1;
      @(negedge clk);
      read = 1'b0; write = 1'b0;
      repeat (33) @(negedge clk);
      rd(5'h04);
      n_tests++;
      if (data_out !== 8'h00 || wr_count !== 16'd0 || err !== 1'b0 || rd_count !== 16'd1) begin
         n_fail++;
         $display("FAIL init_ignores: got dout=%h wc=%0d err=%b rc=%0d want 00 0 0 1",
                  data_out, wr_count, err, rd_count);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_conflict();
      test_reset_mid_sweep();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the team's 5-bit-address, 8-bit-data read/write strobe memory interface. It implements the memory behind the interface's memory-facing modport: a 32 x 8 storage array with registered read data, a post-reset clear sweep, and protocol error and activity bookkeeping. The testbench-side initiator tasks drive it directly: they set `addr`/`data_in`/strobes on negedge and sample `data_out` on the following negedge.

## Interface
- ADDR_W, 5, address width; depth is 2**ADDR_W words.
- DATA_W, 8, data word width.
- CNT_W, 16, width of the activity counters.
- INIT_VAL, 0, value written to every word during the clear sweep.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- read  input  1  read strobe; level-sampled each rising edge.
- write  input  1  write strobe; level-sampled each rising edge.
- addr  input  ADDR_W  word address.
- data_in  input  DATA_W  write data (to memory).
- data_out  output  DATA_W  registered read data (from memory).
- rd_valid  output  1  one-cycle pulse per completed read; `data_out` updated that cycle.
- ready  output  1  high once the clear sweep has finished.
- err  output  1  sticky flag for a read/write conflict.
- err_clr  input  1  clears `err`.
- wr_count  output  CNT_W  saturating count of accepted writes.
- rd_count  output  CNT_W  saturating count of accepted reads.

## Operation
- FSM states: INIT and RUN.
- INIT is entered on reset. A sweep counter runs 0..2**ADDR_W-1 and writes INIT_VAL to one word per cycle. After the last word is written, the FSM goes to RUN; `ready` is 1 from the first RUN cycle.
- In INIT, all strobes are ignored. They are not counted and do not set `err`.
- In RUN, each rising edge classifies the sampled strobes:
  - write=1, read=0: `mem[addr] <= data_in`; `wr_count` += 1.
  - read=1, write=0: `data_out <= mem[addr]`; `rd_valid` = 1 next cycle; `rd_count` += 1.
  - both 1: conflict. No memory access and no counter change. `data_out` holds its value, `rd_valid` = 0, and `err` is set.
  - both 0: idle. `data_out` holds its value, `rd_valid` = 0.
- Strobes are level-sensitive. A strobe held high for N cycles gives N accesses. For example, a read held high returns `mem[addr]` every cycle, with `rd_valid` high every cycle.
- Single port: only one operation per cycle. A read in the cycle after a write to the same address returns the newly written data.
- `err` priority: if a conflict and `err_clr` occur in the same cycle, `err` ends at 1. `err_clr` alone clears `err` on the next edge.
- Counters saturate at 2**CNT_W-1; they do not wrap.
- Reset values: `data_out` = 0, `rd_valid` = 0, `ready` = 0, `err` = 0, `wr_count` = 0, `rd_count` = 0, sweep counter = 0, state = INIT.
- Reset asserted mid-sweep or mid-operation restarts INIT from word 0. All memory contents are re-cleared.

## Timing
- Read latency is 1 clock. Strobe and `addr` are sampled at rising edge k; `data_out` and `rd_valid` are valid after edge k. Both are stable at the next negedge, which is where the initiator samples.
- Write latency is 1 clock. Data is stored at edge k and is readable by a read sampled at edge k+1.
- Clear sweep lasts 2**ADDR_W cycles, 32 by default. With `rst_n` released before edge 0, `ready` rises after edge 32.
- Counters and `err` update at the same edge as the access that causes them.
- `ready`, `err`, `rd_valid`, `data_out` and the counters are all registered outputs; no combinational input-to-output path.

## Test plan
- Reset, then idle 40 cycles -> `ready` = 0 through edge 31 and 1 from edge 32. Reads of addr 0x00, 0x0F and 0x1F return 0x00 with `rd_valid` pulses.
- Write 0xA5 to 0x03, then 0x3C to 0x1F, then read both -> `data_out` = 0xA5 then 0x3C, each one cycle after its read strobe. `wr_count` = 2, `rd_count` = 2.
- Write 0x77 to 0x0A at edge k, read 0x0A at edge k+1 -> `data_out` = 0x77 after edge k+1.
- Drive read = write = 1 at 0x05 (previously 0x11), with `data_in` = 0xEE -> `err` = 1; mem[0x05] still reads 0x11; counters unchanged. Then pulse `err_clr` -> `err` = 0. Repeat with a conflict and `err_clr` in the same cycle -> `err` stays 1.
- Write 0x55 to 0x02, assert `rst_n` = 0 mid-sweep of a second reset at word 10 -> the sweep restarts at 0, `ready` is 0 for 32 cycles after release, and mem[0x02] reads 0x00.
- With CNT_W = 2, issue 5 writes -> `wr_count` saturates at 3.
